controller_nios_0_cpu_mul_combine: RTL and testbench

//  Downstream of controller_nios_0_cpu_mult_cell. Tracks which M-stage cycle holds a real
//  MUL, sums the three 16x16 partial products into the 32-bit low-word product, and

---
 rtl/controller_nios_0_cpu_mul_combine.sv | 153 +++++++++++++++
 tb/tb_controller_nios_0_cpu_mul_combine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_nios_0_cpu_mul_combine.sv
// Combines the three registered 16x16 partial products from the mult cell into the
// 32-bit low-word product and hands it to writeback through a 2-entry valid/ready FIFO.
module controller_nios_0_cpu_mul_combine #(
    parameter int TAG_W  = 5,
    parameter int FIFO_D = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             E_mul_valid,
    input  logic [TAG_W-1:0] E_dst_tag,
    input  logic             M_en,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    output logic             M_stall,
    output logic             W_valid,
    input  logic             W_ready,
    output logic [31:0]      W_result,
    output logic [TAG_W-1:0] W_dst_tag,
    output logic             W_overflow
);

    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_D);

    // M-stage tracker: mirrors the mult cell register so p1..p3 always belong to m_tag
    logic             m_valid_q, m_valid_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;

    // FIFO: the head slot drives W_* directly; the tail slot only exists while count==2
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [31:0]      head_result_q, head_result_d;
    logic [TAG_W-1:0] head_tag_q, head_tag_d;
    logic [31:0]      tail_result_q, tail_result_d;
    logic [TAG_W-1:0] tail_tag_q, tail_tag_d;
    logic             overflow_q, overflow_d;

    logic [31:0] cross_sum;
    logic [31:0] product;
    logic        push;
    logic        pop;
    logic        full;

    // Carries out of bit 31 are dropped on purpose: only the low word is architecturally
    // visible, and mod-2^32 arithmetic makes the result correct for signed operands too.
    always_comb begin
        cross_sum = M_mul_cell_p2 + M_mul_cell_p3;
        product   = M_mul_cell_p1 + (cross_sum << 16);
    end

    always_comb begin
        push = M_en & m_valid_q;
        pop  = valid_q & W_ready;
        full = (cnt_q == CNT_FULL);
    end

    // NOTE: every always_comb output gets its default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        m_valid_d = m_valid_q;
        m_tag_d   = m_tag_q;
        if (M_en) begin
            m_valid_d = E_mul_valid;
            m_tag_d   = E_dst_tag;
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        head_result_d = head_result_q;
        head_tag_d    = head_tag_q;
        tail_result_d = tail_result_q;
        tail_tag_d    = tail_tag_q;
        overflow_d    = overflow_q | (push & full & ~pop);

        // When the last entry is popped the head is left untouched, so W_* keep the last value.
        case (cnt_q)
            CNT_EMPTY: begin
                if (push) begin
                    head_result_d = product;
                    head_tag_d    = m_tag_q;
                    cnt_d         = CNT_ONE;
                end
            end
            CNT_ONE: begin
                if (push && pop) begin
                    head_result_d = product;
                    head_tag_d    = m_tag_q;
                end else if (push) begin
                    tail_result_d = product;
                    tail_tag_d    = m_tag_q;
                    cnt_d         = CNT_FULL;
                end else if (pop) begin
                    cnt_d = CNT_EMPTY;
                end
            end
            default: begin
                // Full: a push without a pop is dropped and flagged via overflow_d above.
                if (pop) begin
                    head_result_d = tail_result_q;
                    head_tag_d    = tail_tag_q;
                    if (push) begin
                        tail_result_d = product;
                        tail_tag_d    = m_tag_q;
                    end else begin
                        cnt_d = CNT_ONE;
                    end
                end
            end
        endcase

        valid_d = (cnt_d != CNT_EMPTY);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    // NOTE: the FIFO storage is reset as well, because W_result/W_dst_tag must read zero
    // out of reset rather than whatever the RAM-like slots powered up with.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q     <= 1'b0;
            m_tag_q       <= '0;
            cnt_q         <= CNT_EMPTY;
            valid_q       <= 1'b0;
            head_result_q <= '0;
            head_tag_q    <= '0;
            tail_result_q <= '0;
            tail_tag_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            m_valid_q     <= m_valid_d;
            m_tag_q       <= m_tag_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            head_result_q <= head_result_d;
            head_tag_q    <= head_tag_d;
            tail_result_q <= tail_result_d;
            tail_tag_q    <= tail_tag_d;
            overflow_q    <= overflow_d;
        end
    end

    // Stall depends only on flops and W_ready: a pop this edge frees the slot the push needs.
    assign M_stall    = m_valid_q & full & ~W_ready;
    assign W_valid    = valid_q;
    assign W_result   = head_result_q;
    assign W_dst_tag  = head_tag_q;
    assign W_overflow = overflow_q;

endmodule

// File: tb/tb_controller_nios_0_cpu_mul_combine.sv
// Scoreboard bench: stimulus pushes hand-computed {tag,result} pairs; a negedge monitor
// pops and compares every accepted W_* transfer, while directed checks cover stall/overflow/reset.
module tb_controller_nios_0_cpu_mul_combine;

    localparam int TAG_W = 5;

    logic             clk;
    logic             reset_n;
    logic             E_mul_valid;
    logic [TAG_W-1:0] E_dst_tag;
    logic             M_en;
    logic [31:0]      M_mul_cell_p1;
    logic [31:0]      M_mul_cell_p2;
    logic [31:0]      M_mul_cell_p3;
    logic             M_stall;
    logic             W_valid;
    logic             W_ready;
    logic [31:0]      W_result;
    logic [TAG_W-1:0] W_dst_tag;
    logic             W_overflow;

    logic [31:0] e_s1;
    logic [31:0] e_s2;

    logic [TAG_W+31:0] sb[$];
    int n_cmp = 0;
    int n_err = 0;

    controller_nios_0_cpu_mul_combine #(.TAG_W(TAG_W), .FIFO_D(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .E_mul_valid   (E_mul_valid),
        .E_dst_tag     (E_dst_tag),
        .M_en          (M_en),
        .M_mul_cell_p1 (M_mul_cell_p1),
        .M_mul_cell_p2 (M_mul_cell_p2),
        .M_mul_cell_p3 (M_mul_cell_p3),
        .M_stall       (M_stall),
        .W_valid       (W_valid),
        .W_ready       (W_ready),
        .W_result      (W_result),
        .W_dst_tag     (W_dst_tag),
        .W_overflow    (W_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the upstream mult cell: registers partial products when M_en is high.
    always @(posedge clk) begin
        if (M_en) begin
            M_mul_cell_p1 <= {16'h0, e_s1[15:0]}  * {16'h0, e_s2[15:0]};
            M_mul_cell_p2 <= {16'h0, e_s1[15:0]}  * {16'h0, e_s2[31:16]};
            M_mul_cell_p3 <= {16'h0, e_s1[31:16]} * {16'h0, e_s2[15:0]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One M_en=1 edge; a MUL the FIFO is expected to keep is queued on the scoreboard.
    task automatic issue(input logic mul, input logic [TAG_W-1:0] tag, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp, input logic accept);
        E_mul_valid = mul;
        E_dst_tag   = tag;
        e_s1        = s1;
        e_s2        = s2;
        M_en        = 1'b1;
        if (mul && accept) sb.push_back({tag, exp});
        cycle();
        E_mul_valid = 1'b0;
    endtask

    task automatic bubble();
        issue(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: every transfer the DUT completes is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && W_valid && W_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got tag %0d result 0x%08h expected none",
                         W_dst_tag, W_result);
            end else begin
                logic [TAG_W+31:0] exp;
                exp = sb.pop_front();
                check("w_result", W_result, exp[31:0]);
                check("w_dst_tag", 32'(W_dst_tag), 32'(exp[TAG_W+31:32]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        M_en        = 1'b0;
        E_mul_valid = 1'b0;
        E_dst_tag   = '0;
        e_s1        = '0;
        e_s2        = '0;
        W_ready     = 1'b0;
        #12;
        check("rst_w_valid", 32'(W_valid), 32'h0);
        check("rst_w_result", W_result, 32'h0);
        check("rst_w_dst_tag", 32'(W_dst_tag), 32'h0);
        check("rst_m_stall", 32'(M_stall), 32'h0);
        check("rst_w_overflow", 32'(W_overflow), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        // Single MUL: W_valid exactly two edges after issue, for one cycle
        W_ready = 1'b1;
        issue(1'b1, 5'd7, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b1);
        check("t1_not_early", 32'(W_valid), 32'h0);
        bubble();
        check("t1_valid", 32'(W_valid), 32'h1);
        bubble();
        check("t1_one_cycle", 32'(W_valid), 32'h0);

        // Wrap-around and signed operands
        issue(1'b1, 5'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        issue(1'b1, 5'd2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1);
        issue(1'b1, 5'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b1);
        repeat (3) bubble();

        // Back-pressure: fill, stall with tag 3 in M, then drain in order
        W_ready = 1'b0;
        issue(1'b1, 5'd1, 32'h0001_0000, 32'h0000_0003, 32'h0003_0000, 1'b1);
        issue(1'b1, 5'd2, 32'h0000_0002, 32'h0004_0000, 32'h0008_0000, 1'b1);
        issue(1'b1, 5'd3, 32'h0000_0010, 32'h0000_0010, 32'h0000_0100, 1'b1);
        check("t3_stall", 32'(M_stall), 32'h1);
        M_en = 1'b0;
        cycle();
        cycle();
        check("t3_stall_hold", 32'(M_stall), 32'h1);
        check("t3_head_tag", 32'(W_dst_tag), 32'h1);
        W_ready = 1'b1;
        #1;
        check("t3_stall_release", 32'(M_stall), 32'h0);
        cycle();
        repeat (3) bubble();
        check("t3_no_overflow", 32'(W_overflow), 32'h0);

        // Full FIFO with simultaneous pop and push
        W_ready = 1'b0;
        issue(1'b1, 5'd4, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b1);
        issue(1'b1, 5'd5, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b1);
        issue(1'b1, 5'd6, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b1);
        check("t4_stall", 32'(M_stall), 32'h1);
        W_ready     = 1'b1;
        M_en        = 1'b1;
        E_mul_valid = 1'b0;
        #1;
        check("t4_stall_low", 32'(M_stall), 32'h0);
        cycle();
        check("t4_head_tag", 32'(W_dst_tag), 32'h5);
        check("t4_still_valid", 32'(W_valid), 32'h1);
        check("t4_stall_after", 32'(M_stall), 32'h0);
        repeat (3) bubble();

        // Overflow: push forced into a full FIFO is dropped, flag is sticky
        W_ready = 1'b0;
        issue(1'b1, 5'd8, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b1);
        issue(1'b1, 5'd9, 32'h0000_0100, 32'h0000_0100, 32'h0001_0000, 1'b1);
        issue(1'b1, 5'd10, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0);
        check("t5_stall", 32'(M_stall), 32'h1);
        bubble();
        check("t5_overflow", 32'(W_overflow), 32'h1);
        check("t5_head_intact", 32'(W_dst_tag), 32'h8);
        check("t5_valid", 32'(W_valid), 32'h1);
        M_en = 1'b0;
        cycle();
        check("t5_overflow_sticky", 32'(W_overflow), 32'h1);
        W_ready = 1'b1;
        cycle();
        cycle();
        check("t5_drained", 32'(W_valid), 32'h0);
        check("t5_overflow_kept", 32'(W_overflow), 32'h1);

        // Bubbles: M_en toggling, non-MUL ops and stalled E contents never pushed
        issue(1'b1, 5'd11, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
        M_en        = 1'b0;
        E_mul_valid = 1'b1;
        E_dst_tag   = 5'd13;
        e_s1        = 32'h1111_1111;
        cycle();
        check("t6_hold_no_push", 32'(W_valid), 32'h0);
        bubble();
        check("t6_pushed", 32'(W_valid), 32'h1);
        issue(1'b1, 5'd12, 32'h0003_0000, 32'h0000_0005, 32'h000F_0000, 1'b1);
        M_en        = 1'b0;
        E_mul_valid = 1'b1;
        E_dst_tag   = 5'd13;
        cycle();
        cycle();
        repeat (3) bubble();

        // Reset with two entries queued discards them and clears the sticky flag
        W_ready = 1'b0;
        issue(1'b1, 5'd14, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 1'b1);
        issue(1'b1, 5'd15, 32'h0000_0004, 32'h0000_0005, 32'h0000_0014, 1'b1);
        bubble();
        check("t6_full_before_rst", 32'(W_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_w_valid", 32'(W_valid), 32'h0);
        check("t6_rst_overflow", 32'(W_overflow), 32'h0);
        check("t6_rst_m_stall", 32'(M_stall), 32'h0);
        sb.delete();
        M_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        W_ready = 1'b1;
        issue(1'b1, 5'd3, 32'h0000_0010, 32'h0000_0020, 32'h0000_0200, 1'b1);
        repeat (3) bubble();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
